pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CTRL_W, 4, control-field width (RegWrite/MemtoReg/MemRead/MemWrite class signals).
- DATA_W, 32, width of one data field.
- NDATA, 2, number of data fields carried (e.g. ALU result, store data).
- RD_W, 5, destination-register address width.
- CNT_W, 16, stall-counter width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all state updates on the rising edge.
- rst_n_i, in, 1, reset, asynchronous, active-low.
- in_valid_i, in, 1, upstream stage holds a valid instruction.
- in_ready_o, out, 1, block can accept this cycle.
- ctrl_i, in, CTRL_W, control bits.
- data_i, in, NDATA*DATA_W, packed data fields; field k occupies bits [k*DATA_W +: DATA_W].
- rd_i, in, RD_W, destination register address.
- flush_i, in, 1, synchronous squash of all held entries.
- out_valid_o, out, 1, output entry valid.
- out_ready_i, in, 1, downstream accepts this cycle.
- ctrl_o, out, CTRL_W, control bits of the output entry.
- data_o, out, NDATA*DATA_W, data of the output entry.
- rd_o, out, RD_W, destination register address of the output entry.
- stall_cnt_o, out, CNT_W, saturating count of back-pressure cycles.
- cnt_clr_i, in, 1, synchronous clear of stall_cnt_o.

Function
REQ-003 The block SHALL hold two entries: a main register driving the outputs and a skid register. Each entry SHALL have its own valid bit.
REQ-004 An input transfer SHALL occur when in_valid_i and in_ready_o are both 1 at a rising edge. An output transfer SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-005 in_ready_o SHALL equal NOT skid-valid. It SHALL be a registered value with no combinational path from out_ready_i.
REQ-006 Latency SHALL be 1 cycle: an input accepted into an empty main register SHALL appear on the outputs the next cycle.
REQ-007 On an input transfer, the entry SHALL go to the main register if main is empty or main is transferring out in the same cycle with skid empty. Otherwise it SHALL go to the skid register.
REQ-008 When main transfers out and skid is valid, skid SHALL move into main on the same edge and skid SHALL become empty. An input arriving in that same cycle SHALL go to skid.
REQ-009 Entries SHALL leave in acceptance order. No entry SHALL be duplicated or dropped except under flush.
REQ-010 While out_valid_o=0, ctrl_o SHALL be forced to all-zero, so a bubble never writes the register file or memory. data_o and rd_o SHALL hold their last value.
REQ-011 flush_i=1 at an edge SHALL clear both valid bits. An input presented in the same cycle SHALL be discarded. Flush SHALL take priority over every simultaneous transfer.
REQ-012 stall_cnt_o SHALL increment by 1 on each edge where out_valid_o=1 and out_ready_i=0, and SHALL saturate at 2^CNT_W-1.
REQ-013 cnt_clr_i=1 SHALL set stall_cnt_o to 0 on that edge. Clear SHALL take priority over increment.
REQ-014 Back-to-back throughput SHALL be one entry per cycle while out_ready_i=1.
REQ-015 With both entries full and out_ready_i=0, all state SHALL hold unchanged, and in_ready_o=0.

Reset
REQ-016 rst_n_i=0 SHALL immediately, independent of clk_i, set the following: both valid bits 0, out_valid_o=0, ctrl_o=0, data_o=0, rd_o=0, skid contents 0, stall_cnt_o=0, in_ready_o=1.
REQ-017 Reset asserted mid-operation SHALL discard all held entries. The first edge after rst_n_i rises SHALL accept input normally.

Verification
REQ-018 A bench SHALL cover the following directed scenarios:
- Single pass: rst, then in_valid_i=1, ctrl_i=4'b1010, data_i={32'h12345678,32'h0000_0004}, rd_i=5'd7 for one cycle, out_ready_i=1 -> next cycle out_valid_o=1 with identical fields; following cycle out_valid_o=0 and ctrl_o=0.
- Stream: 8 entries rd_i=1..8 on consecutive cycles, out_ready_i=1 -> outputs rd_o=1..8 on consecutive cycles, in_ready_o stays 1, stall_cnt_o=0.
- Back-pressure: out_ready_i=0 while sending rd_i=1,2,3 -> rd 1 in main, 2 in skid, in_ready_o=0 after the second accept, 3 held upstream. Then release -> outputs 1,2,3 in order and stall_cnt_o equals the stalled cycle count.
- Flush: main and skid full, flush_i=1 with in_valid_i=1, rd_i=9 -> next cycle out_valid_o=0, ctrl_o=0, in_ready_o=1, and rd 9 is never output.
- Counter: hold out_valid_o=1, out_ready_i=0 for 70000 cycles with CNT_W=16 -> stall_cnt_o=16'hFFFF. Then cnt_clr_i=1 concurrent with a stall -> 0.
- Async reset: rst_n_i low between clock edges with both entries full -> outputs zero before the next edge, in_ready_o=1.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with a registered ready, bubble-safe
// control output, synchronous flush and a saturating back-pressure counter.
module pipe_skid_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int NDATA  = 2,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [NDATA*DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]         rd_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [NDATA*DATA_W-1:0] data_o,
    output logic [RD_W-1:0]         rd_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    input  logic                    cnt_clr_i
);

    localparam int DW = NDATA * DATA_W;

    logic              r_mainValid;
    logic              r_skidValid;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DW-1:0]     r_mainData;
    logic [DW-1:0]     r_skidData;
    logic [RD_W-1:0]   r_mainRd;
    logic [RD_W-1:0]   r_skidRd;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_inXfer;
    logic w_outXfer;

    // Ready depends only on the skid flop, so out_ready_i never reaches in_ready_o.
    assign w_inXfer  = in_valid_i & ~r_skidValid;
    assign w_outXfer = r_mainValid & out_ready_i;

    assign in_ready_o  = ~r_skidValid;
    assign out_valid_o = r_mainValid;
    assign ctrl_o      = r_mainValid ? r_mainCtrl : '0;
    assign data_o      = r_mainData;
    assign rd_o        = r_mainRd;
    assign stall_cnt_o = r_stallCnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_mainCtrl  <= '0;
            r_skidCtrl  <= '0;
            r_mainData  <= '0;
            r_skidData  <= '0;
            r_mainRd    <= '0;
            r_skidRd    <= '0;
        end else if (flush_i) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_outXfer && r_skidValid) begin
            // Skid full implies ready was low, so no input can land this cycle.
            r_mainCtrl  <= r_skidCtrl;
            r_mainData  <= r_skidData;
            r_mainRd    <= r_skidRd;
            r_skidValid <= 1'b0;
        end else if (w_inXfer && (!r_mainValid || w_outXfer)) begin
            r_mainCtrl  <= ctrl_i;
            r_mainData  <= data_i;
            r_mainRd    <= rd_i;
            r_mainValid <= 1'b1;
        end else if (w_inXfer) begin
            r_skidCtrl  <= ctrl_i;
            r_skidData  <= data_i;
            r_skidRd    <= rd_i;
            r_skidValid <= 1'b1;
        end else if (w_outXfer) begin
            r_mainValid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stallCnt <= '0;
        end else if (cnt_clr_i) begin
            r_stallCnt <= '0;
        end else if (r_mainValid && !out_ready_i && !(&r_stallCnt)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a FIFO-of-two reference model compared
// every cycle, directed scenarios with literal expectations, and random traffic.
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [3:0]  c;
        logic [63:0] d;
        logic [4:0]  r;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  ctrl_i;
    logic [63:0] data_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  ctrl_o;
    logic [63:0] data_o;
    logic [4:0]  rd_o;
    logic [15:0] stall_cnt_o;
    logic        cnt_clr_i;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: an ordered list of at most two entries plus the last shown entry.
    ent_t        q[$];
    ent_t        lastShown;
    logic [15:0] mStall;

    pipe_skid_reg dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ctrl_i      (ctrl_i),
        .data_i      (data_i),
        .rd_i        (rd_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ctrl_o      (ctrl_o),
        .data_o      (data_o),
        .rd_o        (rd_o),
        .stall_cnt_o (stall_cnt_o),
        .cnt_clr_i   (cnt_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n_i) begin
        q.delete();
        lastShown = '0;
        mStall    = '0;
    end

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            q.delete();
            lastShown = '0;
            mStall    = '0;
        end else begin
            int  sz;
            bit  outX;
            bit  inX;
            sz = q.size();
            if (cnt_clr_i) mStall = '0;
            else if (sz > 0 && !out_ready_i && mStall != 16'hFFFF) mStall = mStall + 16'd1;
            if (flush_i) begin
                q.delete();
            end else begin
                outX = (sz > 0) && out_ready_i;
                inX  = in_valid_i && (sz < 2);
                if (outX) void'(q.pop_front());
                if (inX) q.push_back('{c: ctrl_i, d: data_i, r: rd_i});
            end
            if (q.size() > 0) lastShown = q[0];
        end
    end

    // Every cycle: the DUT must present exactly what the model says.
    always @(negedge clk_i) begin
        checkOutput("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
        checkOutput("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
        checkOutput("ctrl", 64'(ctrl_o), (q.size() > 0) ? 64'(q[0].c) : 64'd0);
        checkOutput("data", data_o, lastShown.d);
        checkOutput("rd", 64'(rd_o), 64'(lastShown.r));
        checkOutput("stall_cnt", 64'(stall_cnt_o), 64'(mStall));
    end

    // Inputs change only at the falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [63:0] d,
                                 input logic [4:0] r, input logic ordy, input logic fl,
                                 input logic clr);
        in_valid_i  = v;
        ctrl_i      = c;
        data_i      = d;
        rd_i        = r;
        out_ready_i = ordy;
        flush_i     = fl;
        cnt_clr_i   = clr;
        @(negedge clk_i);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 4'h0, 64'h0, 5'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic fillBoth();
        applyStimulus(1'b1, 4'h3, 64'hA, 5'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h5, 64'hB, 5'd2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        in_valid_i = 0; ctrl_i = 0; data_i = 0; rd_i = 0;
        out_ready_i = 0; flush_i = 0; cnt_clr_i = 0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready_o), 64'd1);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Single pass
        applyStimulus(1'b1, 4'b1010, {32'h12345678, 32'h0000_0004}, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("single out_valid", 64'(out_valid_o), 64'd1);
        checkOutput("single ctrl", 64'(ctrl_o), 64'hA);
        checkOutput("single data", data_o, 64'h12345678_00000004);
        checkOutput("single rd", 64'(rd_o), 64'd7);
        idle(1'b1);
        checkOutput("single bubble valid", 64'(out_valid_o), 64'd0);
        checkOutput("single bubble ctrl", 64'(ctrl_o), 64'd0);
        checkOutput("single hold rd", 64'(rd_o), 64'd7);

        // Stream of eight
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 4'h1, 64'(i * 3), 5'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("stream rd", 64'(rd_o), 64'(i));
            checkOutput("stream in_ready", 64'(in_ready_o), 64'd1);
        end
        idle(1'b1);
        checkOutput("stream stall", 64'(stall_cnt_o), 64'd0);

        // Back-pressure
        applyStimulus(1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b1);
        fillBoth();
        checkOutput("bp in_ready", 64'(in_ready_o), 64'd0);
        checkOutput("bp main rd", 64'(rd_o), 64'd1);
        applyStimulus(1'b1, 4'h6, 64'hC, 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 64'hC, 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("bp second rd", 64'(rd_o), 64'd2);
        applyStimulus(1'b1, 4'h6, 64'hC, 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("bp third rd", 64'(rd_o), 64'd3);
        checkOutput("bp stall count", 64'(stall_cnt_o), 64'd2);
        idle(1'b1);

        // Flush with simultaneous input
        fillBoth();
        applyStimulus(1'b1, 4'hF, 64'h9, 5'd9, 1'b0, 1'b1, 1'b0);
        checkOutput("flush out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("flush ctrl", 64'(ctrl_o), 64'd0);
        checkOutput("flush in_ready", 64'(in_ready_o), 64'd1);
        repeat (3) idle(1'b1);

        // Counter saturation and clear
        applyStimulus(1'b1, 4'h2, 64'h77, 5'd4, 1'b0, 1'b0, 1'b1);
        repeat (70000) idle(1'b0);
        checkOutput("cnt saturate", 64'(stall_cnt_o), 64'hFFFF);
        applyStimulus(1'b0, 4'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("cnt clear", 64'(stall_cnt_o), 64'd0);
        idle(1'b1);

        // Asynchronous reset between edges
        fillBoth();
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("areset out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("areset ctrl", 64'(ctrl_o), 64'd0);
        checkOutput("areset data", data_o, 64'd0);
        checkOutput("areset rd", 64'(rd_o), 64'd0);
        checkOutput("areset in_ready", 64'(in_ready_o), 64'd1);
        checkOutput("areset stall", 64'(stall_cnt_o), 64'd0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        applyStimulus(1'b1, 4'h8, 64'h55, 5'd11, 1'b1, 1'b0, 1'b0);
        checkOutput("post-reset accept", 64'(rd_o), 64'd11);

        // Random traffic, with one reset dropped in partway
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n_i = 1'b0;
                @(negedge clk_i);
                #2 rst_n_i = 1'b1;
                @(negedge clk_i);
            end
            applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), {$urandom, $urandom},
                          5'($urandom), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
